// File: rtl/life_step_engine.sv
// life_step_engine: double-banked Game-of-Life stepper with a configurable
// birth/survive rule. One cell is evaluated per clock, and the banks swap on commit.
// Optional feature: define TORUS_WRAP_EN to make neighbour coordinates wrap
// around the map edges. Without it, off-map neighbours count as dead.
module life_step_engine #(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int ADDR_W     = 8,
  parameter int GEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_req,
  input  logic              clear_req,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wAddrR,
  input  logic [ADDR_W-1:0] wAddrC,
  input  logic              write_data,
  input  logic [ADDR_W-1:0] rAddrR,
  input  logic [ADDR_W-1:0] rAddrC,
  output logic              read_data,
  input  logic [8:0]        birth_mask,
  input  logic [8:0]        survive_mask,
  output logic              busy,
  output logic              step_done,
  output logic [GEN_W-1:0]  gen_count,
  output logic [12:0]       population
);

  localparam int CELLS = MAP_WIDTH * MAP_HEIGHT;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [ADDR_W-1:0] ROW_LIM  = ADDR_W'(MAP_HEIGHT);
  localparam logic [ADDR_W-1:0] COL_LIM  = ADDR_W'(MAP_WIDTH);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAP_WIDTH - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, COMMIT, CLEAR} state_t;

  state_t state, state_nx;

  // Cell banks are flat row-major vectors: cell (r,c) lives at bit r*MAP_WIDTH+c.
  logic [CELLS-1:0] bank0, bank1;
  logic             sel;
  logic [CELLS-1:0] cur_map, nxt_map;

  logic [ADDR_W-1:0] row, col;
  logic [IW-1:0]     sweep_idx;
  logic [12:0]       acc;

  logic [3:0]        nbr;
  logic              cur_cell, next_cell;
  int                nb_r, nb_c;
  logic              nb_in;

  logic              wr_hit, wr_old;
  logic [IW-1:0]     wr_idx;
  logic              rd_in;
  logic [IW-1:0]     rd_idx;
  logic [CELLS-1:0]  rd_src;

  assign cur_map = sel ? bank1 : bank0;
  assign nxt_map = sel ? bank0 : bank1;
  assign busy    = (state != IDLE);

  assign wr_hit = (state == IDLE) && write_en && (wAddrR < ROW_LIM) && (wAddrC < COL_LIM);
  assign wr_idx = IW'(int'(wAddrR) * MAP_WIDTH + int'(wAddrC));
  assign wr_old = cur_map[wr_idx];

  assign rd_in  = (rAddrR < ROW_LIM) && (rAddrC < COL_LIM);
  assign rd_idx = IW'(int'(rAddrR) * MAP_WIDTH + int'(rAddrC));
  // During COMMIT the freshly computed bank is read so the new generation is
  // visible in the cycle right after COMMIT, when the bank select has flipped.
  assign rd_src = (state == COMMIT) ? nxt_map : cur_map;

  // Count live neighbours of the cell under the sweep pointer, from the cur bank.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    nbr   = '0;
    nb_r  = 0;
    nb_c  = 0;
    nb_in = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nb_r = int'(row) + dr;
        nb_c = int'(col) + dc;
`ifdef TORUS_WRAP_EN
        if (nb_r < 0) nb_r = nb_r + MAP_HEIGHT;
        else if (nb_r >= MAP_HEIGHT) nb_r = nb_r - MAP_HEIGHT;
        if (nb_c < 0) nb_c = nb_c + MAP_WIDTH;
        else if (nb_c >= MAP_WIDTH) nb_c = nb_c - MAP_WIDTH;
        nb_in = 1'b1;
`else
        nb_in = (nb_r >= 0) && (nb_r < MAP_HEIGHT) && (nb_c >= 0) && (nb_c < MAP_WIDTH);
`endif
        if (!(dr == 0 && dc == 0) && nb_in)
          nbr = nbr + {3'b000, cur_map[IW'(nb_r * MAP_WIDTH + nb_c)]};
      end
    end
  end

  assign cur_cell  = cur_map[sweep_idx];
  assign next_cell = cur_cell ? survive_mask[nbr] : birth_mask[nbr];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: a clear request wins over a step request; both are
  // ignored outside IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (clear_req) state_nx = CLEAR;
               else if (step_req) state_nx = SWEEP;
      SWEEP:   if (sweep_idx == IDX_LAST) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Banks, sweep pointer, counters and the registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the banks are plain flops rather than RAM, so they can be
      // reset here alongside the control state.
      bank0      <= '0;
      bank1      <= '0;
      sel        <= 1'b0;
      row        <= '0;
      col        <= '0;
      sweep_idx  <= '0;
      acc        <= '0;
      gen_count  <= '0;
      population <= '0;
      step_done  <= 1'b0;
      read_data  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      step_done <= (state == COMMIT);
      read_data <= rd_in && (state != CLEAR) && rd_src[rd_idx];

      unique case (state)
        IDLE: begin
          row       <= '0;
          col       <= '0;
          sweep_idx <= '0;
          acc       <= '0;
          // The edit lands on the same edge that samples step_req, so a
          // sweep that starts next cycle already sees the edited cell.
          if (wr_hit) begin
            if (sel) bank1[wr_idx] <= write_data;
            else     bank0[wr_idx] <= write_data;
            if (wr_old != write_data)
              population <= write_data ? population + 13'd1 : population - 13'd1;
          end
        end
        SWEEP: begin
          if (sel) bank0[sweep_idx] <= next_cell;
          else     bank1[sweep_idx] <= next_cell;
          acc       <= acc + {12'd0, next_cell};
          sweep_idx <= sweep_idx + IW'(1);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + ADDR_W'(1);
          end else begin
            col <= col + ADDR_W'(1);
          end
        end
        COMMIT: begin
          sel        <= ~sel;
          population <= acc;
          gen_count  <= gen_count + GEN_W'(1);
        end
        CLEAR: begin
          if (sel) bank1 <= '0;
          else     bank0 <= '0;
          gen_count  <= '0;
          population <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine on an 8x8 map with the B3/S23 rule.
// Expected maps are written as 64-bit row-major constants (bit r*8+c).
module tb_life_step_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 8;
  localparam int GW = 16;

  localparam logic [63:0] BLINK_H  = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [63:0] BLINK_V  = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [63:0] BLOCK0   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
  localparam logic [63:0] GLIDER   = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                     (64'd1 << 17) | (64'd1 << 18);
  localparam logic [63:0] BLOCK_BR = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step_req = 1'b0;
  logic          clear_req = 1'b0;
  logic          write_en = 1'b0;
  logic [AW-1:0] wAddrR = '0;
  logic [AW-1:0] wAddrC = '0;
  logic          write_data = 1'b0;
  logic [AW-1:0] rAddrR = '0;
  logic [AW-1:0] rAddrC = '0;
  logic          read_data;
  logic [8:0]    birth_mask = 9'b000001000;
  logic [8:0]    survive_mask = 9'b000001100;
  logic          busy;
  logic          step_done;
  logic [GW-1:0] gen_count;
  logic [12:0]   population;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_step_engine #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .ADDR_W(AW), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .clear_req(clear_req),
    .write_en(write_en), .wAddrR(wAddrR), .wAddrC(wAddrC), .write_data(write_data),
    .rAddrR(rAddrR), .rAddrC(rAddrC), .read_data(read_data),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .busy(busy),
    .step_done(step_done), .gen_count(gen_count), .population(population)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic write_cell(input int r, input int c, input logic v);
    write_en = 1'b1; wAddrR = AW'(r); wAddrC = AW'(c); write_data = v;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_map(input logic [63:0] pat);
    pulse_clear();
    for (int i = 0; i < 64; i++)
      if (pat[i]) write_cell(i / 8, i % 8, 1'b1);
  endtask

  task automatic read_map(output logic [63:0] m);
    m = '0;
    for (int i = 0; i < 64; i++) begin
      rAddrR = AW'(i / 8); rAddrC = AW'(i % 8);
      @(negedge clk);
      m[i] = read_data;
    end
  endtask

  // Counts clock edges from the one that samples step_req (edge 1) to the
  // first falling edge where step_done is seen; rd_commit is read_data one
  // cycle earlier, while still in COMMIT.
  task automatic do_step(output int lat, output logic rd_commit);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    lat = 1;
    rd_commit = 1'b0;
    while (step_done !== 1'b1 && lat < 200) begin
      rd_commit = read_data;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [63:0] m;
    int          lat;
    int          bad;
    int          seen;
    logic        rdc;

    // Reset state.
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check("rst_gen", gen_count, 0);
    check("rst_pop", population, 0);
    check("rst_rd", read_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Blinker, with population edits and out-of-range writes.
    load_map(BLINK_H);
    check("blink_pop_load", population, 3);
    write_cell(3, 3, 1'b1);
    check("pop_dup_write", population, 3);
    write_cell(0, 0, 1'b0);
    check("pop_dead_write", population, 3);
    write_cell(3, 2, 1'b0);
    check("pop_kill", population, 2);
    write_cell(3, 2, 1'b1);
    check("pop_revive", population, 3);
    write_cell(8, 0, 1'b1);
    write_cell(0, 8, 1'b1);
    check("pop_oor_write", population, 3);
    rAddrR = 8'd8; rAddrC = 8'd0;
    @(negedge clk);
    check("read_oor", read_data, 0);
    read_map(m);
    check("blink_map0", m, BLINK_H);

    rAddrR = 8'd2; rAddrC = 8'd3;
    @(negedge clk);
    do_step(lat, rdc);
    check("blink_lat", lat, 66);
    check("rd_in_commit_old", rdc, 0);
    check("rd_after_commit_new", read_data, 1);
    check("blink_gen", gen_count, 1);
    check("blink_pop", population, 3);
    @(negedge clk);
    check("done_pulse_len", step_done, 0);
    check("blink_busy_idle", busy, 0);
    read_map(m);
    check("blink_map1", m, BLINK_V);

    // Block still life over three steps.
    load_map(BLOCK0);
    check("block_gen_cleared", gen_count, 0);
    bad = 0;
    for (int s = 0; s < 3; s++) begin
      do_step(lat, rdc);
      if (lat != 66) bad++;
    end
    check("block_lat", bad, 0);
    check("block_gen", gen_count, 3);
    check("block_pop", population, 4);
    read_map(m);
    check("block_map", m, BLOCK0);

    // Step and write requests during a sweep are dropped.
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", busy, 1);
    step_req = 1'b1; write_en = 1'b1; wAddrR = 8'd5; wAddrC = 8'd5; write_data = 1'b1;
    @(negedge clk);
    step_req = 1'b0; write_en = 1'b0;
    lat = 11;
    while (step_done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("mid_lat", lat, 66);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (busy || step_done) seen++;
    end
    check("mid_no_queue", seen, 0);
    check("mid_gen", gen_count, 4);
    check("mid_pop", population, 4);
    read_map(m);
    check("mid_map", m, BLOCK0);

    // Glider over 32 generations.
    load_map(GLIDER);
    bad = 0;
    for (int s = 0; s < 32; s++) begin
      do_step(lat, rdc);
      if (lat != 66) bad++;
    end
    check("glider_lat", bad, 0);
    check("glider_gen", gen_count, 32);
    read_map(m);
`ifdef TORUS_WRAP_EN
    check("glider_pop", population, 5);
    check("glider_map", m, GLIDER);
`else
    check("glider_pop", population, 4);
    check("glider_map", m, BLOCK_BR);
`endif

    // Reset in sweep cycle 20.
    load_map(BLINK_H);
    rAddrR = 8'd3; rAddrC = 8'd3;
    @(negedge clk);
    check("pre_rst_rd", read_data, 1);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", step_done, 0);
    check("mrst_gen", gen_count, 0);
    check("mrst_pop", population, 0);
    check("mrst_rd", read_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy_after", busy, 0);
    read_map(m);
    check("mrst_map", m, 64'd0);

    // Clear and step together: the clear wins.
    load_map(BLINK_H);
    do_step(lat, rdc);
    check("cs_gen_before", gen_count, 1);
    clear_req = 1'b1; step_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; step_req = 1'b0;
    check("cs_busy_clear", busy, 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy || step_done) seen++;
    end
    check("cs_no_step", seen, 0);
    check("cs_pop", population, 0);
    check("cs_gen", gen_count, 0);
    read_map(m);
    check("cs_map", m, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_step_engine.md
LIFE_STEP_ENGINE -- requirements
Module: life_step_engine

Interface
REQ-001 The block SHALL have parameter MAP_WIDTH, default 8, meaning map columns (2..64).
REQ-002 The block SHALL have parameter MAP_HEIGHT, default 8, meaning map rows (2..64).
REQ-003 The block SHALL have parameter ADDR_W, default 8, meaning row/column address width.
REQ-004 The block SHALL have parameter GEN_W, default 16, meaning generation counter width.
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-006 The block SHALL have port rst, input, 1, meaning an asynchronous active-low reset.
REQ-007 The block SHALL have port step_req, input, 1, meaning request one generation step.
REQ-008 The block SHALL have port clear_req, input, 1, meaning kill all cells.
REQ-009 The block SHALL have ports write_en (input, 1), wAddrR and wAddrC (input, ADDR_W each) and write_data (input, 1), together meaning a cell edit.
REQ-010 The block SHALL have ports rAddrR and rAddrC (input, ADDR_W each) and read_data (output, 1), together meaning the display read port.
REQ-011 The block SHALL have ports birth_mask and survive_mask, input, 9 each, where bit n set means the rule applies at n live neighbours.
REQ-012 The block SHALL have port busy, output, 1, meaning a step or clear is in progress.
REQ-013 The block SHALL have port step_done, output, 1, meaning a one-cycle pulse when a step commits.
REQ-014 The block SHALL have port gen_count, output, GEN_W, meaning committed generations since reset or clear.
REQ-015 The block SHALL have port population, output, 13, meaning the live-cell count of the displayed generation.

Function
REQ-016 The block SHALL hold two MAP_WIDTH x MAP_HEIGHT banks, cur and nxt, selected by a bank-select flop.
REQ-017 The FSM SHALL have states IDLE, SWEEP, COMMIT and CLEAR, and SHALL reset to IDLE.
REQ-018 In IDLE, clear_req SHALL go to CLEAR; otherwise step_req SHALL go to SWEEP; clear_req SHALL have priority when both are asserted.
REQ-019 SWEEP SHALL visit one cell per clock in row-major order from (0,0), taking MAP_WIDTH*MAP_HEIGHT cycles, then go to COMMIT.
REQ-020 Per cell, the 8-neighbour live count n SHALL be taken from cur; next = cur ? survive_mask[n] : birth_mask[n]; the result SHALL be written to nxt.
REQ-021 COMMIT SHALL last 1 cycle: toggle the bank select, load population from the sweep accumulator, increment gen_count, then return to IDLE.
REQ-022 step_done SHALL pulse high in the first cycle after COMMIT; total step latency SHALL be MAP_WIDTH*MAP_HEIGHT+2 cycles from the step_req edge.
REQ-023 gen_count SHALL wrap from all-ones to 0.
REQ-024 CLEAR SHALL last 1 cycle: zero the cur bank, zero gen_count and population, then return to IDLE; step_done SHALL stay low.
REQ-025 busy SHALL be high in SWEEP, COMMIT and CLEAR.
REQ-026 step_req, clear_req and write_en SHALL be ignored while busy; requests are not queued.
REQ-027 A write in IDLE SHALL update cur at the clock edge and adjust population by +1/-1 only if the cell state changes.
REQ-028 write_en together with step_req in IDLE SHALL apply the write first, so the sweep sees the edited cell.
REQ-029 A write to an address with row >= MAP_HEIGHT or column >= MAP_WIDTH SHALL be ignored.
REQ-030 read_data SHALL be registered: it returns cur[rAddrR][rAddrC] one cycle after the address, and 0 when the address is out of range.
REQ-031 read_data SHALL show the old generation until COMMIT and the new generation from the cycle after COMMIT.

Reset
REQ-032 Asserting rst SHALL, at any time including mid-SWEEP, force IDLE, clear both banks and the bank select, and zero busy, step_done, gen_count, population and read_data.

Configuration
REQ-033 With TORUS_WRAP_EN defined, neighbour coordinates SHALL wrap modulo MAP_WIDTH/MAP_HEIGHT; without it, off-map neighbours SHALL count as dead.

Verification
REQ-034 The bench SHALL cover: 8x8, B3/S23, horizontal blinker at row 3 cols 2-4, step -> vertical at col 3 rows 2-4, population 3, gen_count 1, step_done after 66 cycles.
REQ-035 The bench SHALL cover: 2x2 block at (0,0), 3 steps -> unchanged, population 4, gen_count 3.
REQ-036 The bench SHALL cover: glider with TORUS_WRAP_EN, 32 steps -> original shape returns offset (+8,+8) mod 8, i.e. identical map; without the macro it decays into a block at the corner.
REQ-037 The bench SHALL cover: step_req plus write mid-SWEEP -> both ignored, busy high, gen_count +1 only.
REQ-038 The bench SHALL cover: rst low at SWEEP cycle 20 -> IDLE, all reads 0, gen_count 0, population 0.
REQ-039 The bench SHALL cover: clear_req and step_req together in IDLE -> CLEAR taken, no step_done, population 0.
